pwm_bar_decoder: RTL and testbench

Receive-side counterpart of the PWM LED bargraph driver. It samples the 8 PWM-modulated LED lines over fixed 2^PWM_BITS-cycle frames and measures each LED's duty cycle. From each frame it decodes the bright-spot position, direction of travel and step period (in frames). It sits on the bargraph output lines as an on-chip self-check/monitor and feeds status to a debug readout.

---
 rtl/pwm_bar_pkg.sv | 29 ++
 rtl/pwm_duty_meter.sv | 43 ++++
 rtl/pwm_bar_decoder.sv | 213 +++++++++++++++++++++
 tb/tb_pwm_bar_decoder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_bar_pkg.sv
// ---------------------------------------------------------------------------
// pwm_bar_pkg
// Shared definitions for the PWM bargraph decoder: LED count, default
// frame/threshold parameters, the per-LED duty level type and the per-frame
// decode outcome type.
// ---------------------------------------------------------------------------
package pwm_bar_pkg;

    localparam int N_LEDS          = 8;
    localparam int DEF_PWM_BITS    = 8;
    localparam int DEF_HIGH_THRESH = 200;
    localparam int DEF_MID_THRESH  = 50;
    localparam int DEF_STEP_W      = 18;

    typedef enum logic [1:0] {
        LVL_OFF  = 2'd0,
        LVL_MID  = 2'd1,
        LVL_FULL = 2'd2
    } level_t;

    typedef enum logic [2:0] {
        DEC_BLANK = 3'd0,
        DEC_ERR   = 3'd1,
        DEC_FIRST = 3'd2,
        DEC_HOLD  = 3'd3,
        DEC_STEP  = 3'd4
    } decode_t;

endpackage

// File: rtl/pwm_duty_meter.sv
// ---------------------------------------------------------------------------
// pwm_duty_meter
// Counts the high cycles of one PWM LED line over a frame. On the frame-end
// strobe the count, including that final cycle's sample, is latched into
// duty and the running counter restarts.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   led        PWM LED line being measured
//   frame_end  high in the last cycle of each frame (shared by all meters)
//   duty       high-cycle count of the last completed frame (0..2^PWM_BITS)
// ---------------------------------------------------------------------------
module pwm_duty_meter
    import pwm_bar_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                led,
    input  logic                frame_end,
    output logic [PWM_BITS:0]   duty
);

    logic [PWM_BITS:0] hi_count;
    logic [PWM_BITS:0] sample;

    assign sample = {{PWM_BITS{1'b0}}, led};

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_count <= '0;
            duty     <= '0;
        end else if (frame_end) begin
            duty     <= hi_count + sample;
            hi_count <= '0;
        end else begin
            hi_count <= hi_count + sample;
        end
    end

endmodule

// File: rtl/pwm_bar_decoder.sv
// ---------------------------------------------------------------------------
// pwm_bar_decoder
// Monitors the 8 PWM LED bargraph lines. Each 2^PWM_BITS-cycle frame the
// per-LED duty is measured and classified OFF/MID/FULL; the pattern is then
// checked for a single bright spot with dim neighbours, and the position,
// direction of travel and frames-per-step period are reported.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   led_in       PWM LED lines, bit i = LED i
//   frame_done   one-cycle pulse when the decode results update
//   pos          decoded bright-spot position
//   pos_valid    last completed frame held a valid pattern
//   dir          0 = moving up, 1 = moving down
//   step_strobe  one-cycle pulse, position moved by exactly one
//   step_period  frames between the last two steps, saturating
//   blank        last frame had all LEDs OFF
//   pattern_err  one-cycle pulse, malformed frame or illegal jump
// ---------------------------------------------------------------------------
module pwm_bar_decoder
    import pwm_bar_pkg::*;
#(
    parameter int PWM_BITS    = DEF_PWM_BITS,
    parameter int HIGH_THRESH = DEF_HIGH_THRESH,
    parameter int MID_THRESH  = DEF_MID_THRESH,
    parameter int STEP_W      = DEF_STEP_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_LEDS-1:0]   led_in,
    output logic                frame_done,
    output logic [2:0]          pos,
    output logic                pos_valid,
    output logic                dir,
    output logic                step_strobe,
    output logic [STEP_W-1:0]   step_period,
    output logic                blank,
    output logic                pattern_err
);

    localparam logic [PWM_BITS-1:0] FC_MAX   = '1;
    localparam logic [STEP_W-1:0]   STEP_MAX = '1;
    localparam logic [PWM_BITS:0]   HIGH_T   = HIGH_THRESH[PWM_BITS:0];
    localparam logic [PWM_BITS:0]   MID_T    = MID_THRESH[PWM_BITS:0];

    logic [PWM_BITS-1:0] fc;
    logic                frame_end;
    logic                frame_end_d;
    logic [PWM_BITS:0]   duty [N_LEDS];
    level_t              lvl  [N_LEDS];

    logic [3:0]          full_cnt;
    logic [2:0]          full_idx;
    logic                any_on;
    logic                shape_ok;
    logic [2:0]          li;
    level_t              want;
    logic                step_up;
    logic                step_dn;
    decode_t             outcome;

    logic                have_ref;
    logic [STEP_W-1:0]   fss;
    logic [STEP_W-1:0]   fss_inc;

    assign frame_end = (fc == FC_MAX);

    for (genvar g = 0; g < N_LEDS; g++) begin : g_meter
        pwm_duty_meter #(
            .PWM_BITS (PWM_BITS)
        ) u_meter (
            .clk       (clk),
            .rst       (rst),
            .led       (led_in[g]),
            .frame_end (frame_end),
            .duty      (duty[g])
        );
    end

    always_comb begin
        for (int i = 0; i < N_LEDS; i++) begin
            if (duty[i] >= HIGH_T) begin
                lvl[i] = LVL_FULL;
            end else if (duty[i] >= MID_T) begin
                lvl[i] = LVL_MID;
            end else begin
                lvl[i] = LVL_OFF;
            end
        end
    end

    // Locate the FULL LED; full_idx is only meaningful when exactly one exists.
    always_comb begin
        full_cnt = '0;
        full_idx = '0;
        any_on   = 1'b0;
        for (int i = 0; i < N_LEDS; i++) begin
            if (lvl[i] == LVL_FULL) begin
                full_cnt = full_cnt + 4'd1;
                full_idx = 3'(i);
            end
            if (lvl[i] != LVL_OFF) begin
                any_on = 1'b1;
            end
        end
    end

    // Compare every LED against the ideal shape around full_idx; the guards
    // on 0 and 7 stop the 3-bit neighbour arithmetic from wrapping round.
    always_comb begin
        shape_ok = (full_cnt == 4'd1);
        li       = '0;
        want     = LVL_OFF;
        for (int i = 0; i < N_LEDS; i++) begin
            li = 3'(i);
            if (li == full_idx) begin
                want = LVL_FULL;
            end else if ((full_idx != 3'd7 && li == full_idx + 3'd1) ||
                         (full_idx != 3'd0 && li == full_idx - 3'd1)) begin
                want = LVL_MID;
            end else begin
                want = LVL_OFF;
            end
            if (lvl[i] != want) begin
                shape_ok = 1'b0;
            end
        end
    end

    assign step_up = (full_idx == pos + 3'd1) && (pos != 3'd7);
    assign step_dn = (full_idx == pos - 3'd1) && (pos != 3'd0);
    assign fss_inc = (fss == STEP_MAX) ? fss : fss + 1'b1;

    always_comb begin
        outcome = DEC_ERR;
        if (!any_on) begin
            outcome = DEC_BLANK;
        end else if (!shape_ok) begin
            outcome = DEC_ERR;
        end else if (!have_ref) begin
            outcome = DEC_FIRST;
        end else if (full_idx == pos) begin
            outcome = DEC_HOLD;
        end else if (step_up || step_dn) begin
            outcome = DEC_STEP;
        end else begin
            outcome = DEC_ERR;
        end
    end

    // Decode runs in the fc=0 cycle, one cycle after duty was latched, so
    // the results and pulses appear in the fc=1 cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fc          <= '0;
            frame_end_d <= 1'b0;
            frame_done  <= 1'b0;
            pos         <= '0;
            pos_valid   <= 1'b0;
            dir         <= 1'b0;
            step_strobe <= 1'b0;
            step_period <= '0;
            blank       <= 1'b0;
            pattern_err <= 1'b0;
            have_ref    <= 1'b0;
            fss         <= '0;
        end else begin
            fc          <= fc + 1'b1;
            frame_end_d <= frame_end;
            frame_done  <= frame_end_d;
            step_strobe <= 1'b0;
            pattern_err <= 1'b0;
            if (frame_end_d) begin
                fss <= fss_inc;
                case (outcome)
                    DEC_BLANK: begin
                        blank     <= 1'b1;
                        pos_valid <= 1'b0;
                        have_ref  <= 1'b0;
                    end
                    DEC_FIRST: begin
                        blank     <= 1'b0;
                        pos_valid <= 1'b1;
                        pos       <= full_idx;
                        have_ref  <= 1'b1;
                    end
                    DEC_HOLD: begin
                        blank     <= 1'b0;
                        pos_valid <= 1'b1;
                        pos       <= full_idx;
                    end
                    DEC_STEP: begin
                        blank       <= 1'b0;
                        pos_valid   <= 1'b1;
                        pos         <= full_idx;
                        step_strobe <= 1'b1;
                        dir         <= step_dn;
                        step_period <= fss_inc;
                        fss         <= '0;
                    end
                    default: begin
                        blank       <= 1'b0;
                        pos_valid   <= 1'b0;
                        have_ref    <= 1'b0;
                        pattern_err <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_bar_decoder.sv
// ---------------------------------------------------------------------------
// tb_pwm_bar_decoder
// Directed bench for pwm_bar_decoder. Frames are driven as right-aligned PWM
// (LED high in the last d cycles of the frame) so the fc=max sample always
// contributes to the measured duty. Results of frame k are sampled in the
// fc=1 cycle of frame k+1. STEP_W is reduced to 3 so step_period saturation
// (7) is reachable in a few frames.
// ---------------------------------------------------------------------------
module tb_pwm_bar_decoder;

    logic        clk;
    logic        rst;
    logic [7:0]  led_in;
    logic        frame_done;
    logic [2:0]  pos;
    logic        pos_valid;
    logic        dir;
    logic        step_strobe;
    logic [2:0]  step_period;
    logic        blank;
    logic        pattern_err;

    int vectors     = 0;
    int miscompares = 0;
    int stray       = 0;
    int cur_duty [8];

    logic [31:0] snap_done, snap_pos, snap_valid, snap_dir;
    logic [31:0] snap_strobe, snap_period, snap_blank, snap_err;

    pwm_bar_decoder #(
        .PWM_BITS    (8),
        .HIGH_THRESH (200),
        .MID_THRESH  (50),
        .STEP_W      (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .led_in      (led_in),
        .frame_done  (frame_done),
        .pos         (pos),
        .pos_valid   (pos_valid),
        .dir         (dir),
        .step_strobe (step_strobe),
        .step_period (step_period),
        .blank       (blank),
        .pattern_err (pattern_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic set_dark();
        for (int i = 0; i < 8; i++) cur_duty[i] = 0;
    endtask

    task automatic set_bar(input int p);
        for (int i = 0; i < 8; i++) begin
            if (i == p) cur_duty[i] = 255;
            else if (i == p - 1 || i == p + 1) cur_duty[i] = 100;
            else cur_duty[i] = 0;
        end
    endtask

    // Drives ncyc cycles of a frame starting at fc=0; snapshots the outputs
    // in the fc=1 cycle and counts any pulse seen in other cycles.
    task automatic applyStimulus(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < 8; i++) led_in[i] = (c >= 256 - cur_duty[i]);
            if (c == 1) begin
                snap_done   = 32'(frame_done);
                snap_pos    = 32'(pos);
                snap_valid  = 32'(pos_valid);
                snap_dir    = 32'(dir);
                snap_strobe = 32'(step_strobe);
                snap_period = 32'(step_period);
                snap_blank  = 32'(blank);
                snap_err    = 32'(pattern_err);
            end else if (frame_done || step_strobe || pattern_err) begin
                stray++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input int e_pos, input int e_valid,
                               input int e_dir, input int e_strobe, input int e_period,
                               input int e_blank, input int e_err);
        chk({tag, ".frame_done"},  snap_done,   1);
        chk({tag, ".pos"},         snap_pos,    e_pos);
        chk({tag, ".pos_valid"},   snap_valid,  e_valid);
        chk({tag, ".dir"},         snap_dir,    e_dir);
        chk({tag, ".step_strobe"}, snap_strobe, e_strobe);
        chk({tag, ".step_period"}, snap_period, e_period);
        chk({tag, ".blank"},       snap_blank,  e_blank);
        chk({tag, ".pattern_err"}, snap_err,    e_err);
    endtask

    task automatic checkReset(input string tag);
        chk({tag, ".frame_done"},  32'(frame_done),  0);
        chk({tag, ".pos"},         32'(pos),         0);
        chk({tag, ".pos_valid"},   32'(pos_valid),   0);
        chk({tag, ".dir"},         32'(dir),         0);
        chk({tag, ".step_strobe"}, 32'(step_strobe), 0);
        chk({tag, ".step_period"}, 32'(step_period), 0);
        chk({tag, ".blank"},       32'(blank),       0);
        chk({tag, ".pattern_err"}, 32'(pattern_err), 0);
    endtask

    initial begin
        int n;
        bit got;

        rst    = 1'b1;
        led_in = '0;
        set_dark();
        repeat (3) @(posedge clk);
        #1;
        checkReset("reset");
        rst = 1'b0;

        // Each applyStimulus drives frame k and checks the results of frame k-1.
        set_bar(3); applyStimulus(256);
        chk("first_frame_no_done", snap_done, 0);
        set_bar(3); applyStimulus(256); checkOutput("static3_first", 3, 1, 0, 0, 0, 0, 0);
        set_bar(3); applyStimulus(256); checkOutput("static3_hold1", 3, 1, 0, 0, 0, 0, 0);
        set_dark(); applyStimulus(256); checkOutput("static3_hold2", 3, 1, 0, 0, 0, 0, 0);
        set_bar(7); applyStimulus(256); checkOutput("blank_a",       3, 0, 0, 0, 0, 1, 0);
        set_dark(); applyStimulus(256); checkOutput("edge7",         7, 1, 0, 0, 0, 0, 0);
        set_bar(0); applyStimulus(256); checkOutput("blank_b",       7, 0, 0, 0, 0, 1, 0);
        set_bar(0); applyStimulus(256); checkOutput("edge0_first",   0, 1, 0, 0, 0, 0, 0);
        set_bar(1); applyStimulus(256); checkOutput("edge0_hold",    0, 1, 0, 0, 0, 0, 0);
        set_bar(2); applyStimulus(256); checkOutput("step0to1_sat",  1, 1, 0, 1, 7, 0, 0);
        set_bar(2); applyStimulus(256); checkOutput("step1to2",      2, 1, 0, 1, 1, 0, 0);
        set_bar(2); applyStimulus(256); checkOutput("hold2_a",       2, 1, 0, 0, 1, 0, 0);
        set_bar(2); applyStimulus(256); checkOutput("hold2_b",       2, 1, 0, 0, 1, 0, 0);
        set_bar(3); applyStimulus(256); checkOutput("hold2_c",       2, 1, 0, 0, 1, 0, 0);
        set_bar(3); applyStimulus(256); checkOutput("step2to3",      3, 1, 0, 1, 4, 0, 0);
        set_bar(3); applyStimulus(256); checkOutput("hold3_a",       3, 1, 0, 0, 4, 0, 0);
        set_bar(3); applyStimulus(256); checkOutput("hold3_b",       3, 1, 0, 0, 4, 0, 0);
        set_bar(4); applyStimulus(256); checkOutput("hold3_c",       3, 1, 0, 0, 4, 0, 0);
        set_bar(3); applyStimulus(256); checkOutput("step3to4",      4, 1, 0, 1, 4, 0, 0);
        set_bar(6); applyStimulus(256); checkOutput("step4to3_down", 3, 1, 1, 1, 1, 0, 0);

        // Threshold boundaries: 200 is FULL, 50 is MID, 49 is OFF.
        set_dark();
        cur_duty[5] = 200; cur_duty[4] = 50; cur_duty[6] = 50; cur_duty[0] = 49;
        applyStimulus(256); checkOutput("jump3to6", 3, 0, 1, 0, 1, 0, 1);

        set_dark();
        cur_duty[1] = 255; cur_duty[5] = 200;
        applyStimulus(256); checkOutput("boundary_pos5_first", 5, 1, 1, 0, 1, 0, 0);

        set_bar(4); applyStimulus(256); checkOutput("two_full",       5, 0, 1, 0, 1, 0, 1);
        set_dark(); applyStimulus(256); checkOutput("after_err_pos4", 4, 1, 1, 0, 1, 0, 0);
        set_dark(); applyStimulus(256); checkOutput("dark_a",         4, 0, 1, 0, 1, 1, 0);

        set_dark();
        cur_duty[2] = 255; cur_duty[1] = 100; cur_duty[3] = 49;
        applyStimulus(256); checkOutput("dark_b", 4, 0, 1, 0, 1, 1, 0);

        set_bar(2); applyStimulus(256); checkOutput("neighbour_off", 4, 0, 1, 0, 1, 0, 1);

        // Abort a frame at fc=100 with a one-cycle reset pulse.
        set_bar(3); applyStimulus(100); checkOutput("after_err_pos2", 2, 1, 1, 0, 1, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkReset("midframe_reset");
        rst    = 1'b0;
        led_in = '0;

        n   = 0;
        got = 1'b0;
        while (n < 300 && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (frame_done) got = 1'b1;
        end
        chk("rst_first_done_latency", n, 257);
        chk("rst_dark_frame.blank",       32'(blank),       1);
        chk("rst_dark_frame.pos",         32'(pos),         0);
        chk("rst_dark_frame.pos_valid",   32'(pos_valid),   0);
        chk("rst_dark_frame.pattern_err", 32'(pattern_err), 0);

        chk("no_stray_pulses", stray, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
